// File: rtl/demosaic_frame_ctrl.sv
// Frame-level sequencer for the Bayer demosaic core.
// Holds the core in reset between frames and releases it for one frame per start command.
// Routes core reads to a ping-pong source store and captures core output into a ping-pong
// destination store. Raises completion and hang status.
module demosaic_frame_ctrl #(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_LENGTH    = 100,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned FCNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmd,
  input  logic                  cmd_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic [FCNT_W-1:0]     frame_count,
  output logic                  src_bank,
  output logic                  dst_bank,
  output logic                  core_rst,
  input  logic [ADDR_WIDTH-1:0] core_w_addr,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [ADDR_WIDTH:0]   src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic [ADDR_WIDTH-1:0] core_o_addr,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic                  core_output_valid,
  input  logic                  core_done,
  output logic                  dst_we,
  output logic [ADDR_WIDTH:0]   dst_addr,
  output logic [DATA_WIDTH-1:0] dst_data
);

  localparam int unsigned CycW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] LenMax = (ADDR_WIDTH + 1)'(DATA_LENGTH);
  localparam logic [CycW-1:0]     CycMax = CycW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StRel, StRun, StDone, StErr} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cap_cnt_q, cap_cnt_d;
  logic [CycW-1:0]         cyc_q, cyc_d;
  logic                    terr_q, terr_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  // Source and destination banks always flip together, so one flop serves both.
  logic                    bank_q, bank_d;
  logic                    dst_we_q, dst_we_d;
  logic [ADDR_WIDTH:0]     dst_addr_q, dst_addr_d;
  logic [DATA_WIDTH-1:0]   dst_data_q, dst_data_d;

  logic cmd_start, cmd_abort, cmd_clear;

  assign cmd_start = cmd_valid && (cmd == 2'b01);
  assign cmd_abort = cmd_valid && (cmd == 2'b10);
  assign cmd_clear = cmd_valid && (cmd == 2'b11);

  // Source read path is a straight combinational pass-through.
  assign src_addr     = {bank_q, core_w_addr};
  assign core_data_in = src_data;

  // Next-state, counters and capture register inputs.
  always_comb begin
    state_d    = state_q;
    cap_cnt_d  = cap_cnt_q;
    cyc_d      = cyc_q;
    terr_d     = terr_q;
    fcnt_d     = fcnt_q;
    bank_d     = bank_q;
    dst_we_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          state_d = StRel;
        end else if (cmd_clear) begin
          terr_d = 1'b0;
        end
      end
      StRel: begin
        cap_cnt_d = '0;
        cyc_d     = '0;
        state_d   = cmd_abort ? StIdle : StRun;
      end
      StRun: begin
        // Abort beats both capture and completion in the same cycle.
        if (cmd_abort) begin
          state_d = StIdle;
        end else begin
          if (cyc_q != CycMax) begin
            cyc_d = cyc_q + 1'b1;
          end
          // The core keeps valid high in its finish state; extra beats are dropped.
          if (core_output_valid && (cap_cnt_q < LenMax)) begin
            dst_we_d   = 1'b1;
            dst_addr_d = {bank_q, core_o_addr};
            dst_data_d = core_data_out;
            cap_cnt_d  = cap_cnt_q + 1'b1;
          end
          // Completion takes priority over a timeout in the same cycle.
          if ((cap_cnt_q == LenMax) && core_done) begin
            state_d = StDone;
          end else if (cyc_q == CycMax) begin
            state_d = StErr;
            terr_d  = 1'b1;
          end
        end
      end
      StDone: begin
        fcnt_d  = fcnt_q + 1'b1;
        bank_d  = ~bank_q;
        state_d = StIdle;
      end
      StErr: begin
        if (cmd_clear) begin
          terr_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cap_cnt_q  <= '0;
      cyc_q      <= '0;
      terr_q     <= 1'b0;
      fcnt_q     <= '0;
      bank_q     <= 1'b0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_cnt_q  <= cap_cnt_d;
      cyc_q      <= cyc_d;
      terr_q     <= terr_d;
      fcnt_q     <= fcnt_d;
      bank_q     <= bank_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
    end
  end

  // Status outputs decoded from state. core_rst stays low through DONE so it
  // rises one cycle after frame_done.
  always_comb begin
    busy       = (state_q == StRel) || (state_q == StRun);
    frame_done = (state_q == StDone);
    core_rst   = !((state_q == StRun) || (state_q == StDone));
  end

  assign timeout_err = terr_q;
  assign frame_count = fcnt_q;
  assign src_bank    = bank_q;
  assign dst_bank    = bank_q;
  assign dst_we      = dst_we_q;
  assign dst_addr    = dst_addr_q;
  assign dst_data    = dst_data_q;

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// Self-checking bench for demosaic_frame_ctrl with a behavioural core and store model.
module tb_demosaic_frame_ctrl;

  localparam int DW  = 12;
  localparam int AW  = 7;
  localparam int LEN = 100;
  localparam int TO  = 300;
  localparam int FW  = 8;

  localparam logic [1:0] CmdStart = 2'b01;
  localparam logic [1:0] CmdAbort = 2'b10;
  localparam logic [1:0] CmdClear = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    cmd;
  logic          cmd_valid;
  logic          busy, frame_done, timeout_err;
  logic [FW-1:0] frame_count;
  logic          src_bank, dst_bank, core_rst;
  logic [AW-1:0] core_w_addr;
  logic [DW-1:0] core_data_in;
  logic [AW:0]   src_addr;
  logic [DW-1:0] src_data;
  logic [AW-1:0] core_o_addr;
  logic [DW-1:0] core_data_out;
  logic          core_output_valid, core_done;
  logic          dst_we;
  logic [AW:0]   dst_addr;
  logic [DW-1:0] dst_data;

  demosaic_frame_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_LENGTH(LEN), .TIMEOUT_CYCLES(TO), .FCNT_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err), .frame_count(frame_count),
    .src_bank(src_bank), .dst_bank(dst_bank), .core_rst(core_rst),
    .core_w_addr(core_w_addr), .core_data_in(core_data_in), .src_addr(src_addr),
    .src_data(src_data), .core_o_addr(core_o_addr), .core_data_out(core_data_out),
    .core_output_valid(core_output_valid), .core_done(core_done), .dst_we(dst_we),
    .dst_addr(dst_addr), .dst_data(dst_data)
  );

  // Source frame store: combinational read, both banks.
  logic [DW-1:0] src_mem [256];
  assign src_data = src_mem[src_addr];

  // Packed view of every registered/status output, compared against the reset image.
  wire [34:0] out_vec = {busy, frame_done, timeout_err, frame_count, src_bank, dst_bank,
                         core_rst, dst_we, dst_addr, dst_data};
  localparam logic [34:0] ResetVec = {1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 8'd0, 12'd0};

  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_cnt    = 0;
  int fd_cnt    = 0;
  logic exp_bank = 1'b0;
  int   exp_fcount = 0;

  always @(negedge clk) begin
    if (dst_we === 1'b1) wr_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd = 2'b00; cmd_valid = 1'b0; core_output_valid = 1'b0; core_done = 1'b0;
  endtask

  // Drive one full frame from the core side. finish_abort issues abort together with core_done.
  task automatic run_frame(input int hold, input int gap_pct, input bit finish_abort);
    int w0, f0, idx;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    bit beat;
    w0 = wr_cnt; f0 = fd_cnt; idx = 0;
    cmd = CmdStart; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    total_cnt++;
    if ({core_rst, busy} !== 2'b11) $display("FAIL rel_state got=%b exp=11", {core_rst, busy});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({core_rst, busy} !== 2'b01) $display("FAIL release got=%b exp=01", {core_rst, busy});
    else pass_cnt++;
    while (idx < LEN) begin
      beat = ($urandom_range(0, 99) >= gap_pct);
      d = DW'($urandom);
      core_output_valid = beat; core_o_addr = AW'(idx); core_data_out = d;
      wa = AW'($urandom_range(0, LEN - 1));
      core_w_addr = wa;
      #1;
      total_cnt++;
      if (src_addr !== {exp_bank, wa} || core_data_in !== src_mem[{exp_bank, wa}])
        $display("FAIL src_path got=%h/%h exp=%h/%h", src_addr, core_data_in,
                 {exp_bank, wa}, src_mem[{exp_bank, wa}]);
      else pass_cnt++;
      step();
      total_cnt++;
      if (beat) begin
        if ({dst_we, dst_addr, dst_data} !== {1'b1, exp_bank, AW'(idx), d})
          $display("FAIL capture idx=%0d got=%b/%h/%h exp=1/%h/%h", idx, dst_we, dst_addr,
                   dst_data, {exp_bank, AW'(idx)}, d);
        else pass_cnt++;
        idx++;
      end else begin
        if (dst_we !== 1'b0) $display("FAIL gap_we got=%b exp=0", dst_we);
        else pass_cnt++;
      end
    end
    // Core parks on the last address with valid still high.
    core_output_valid = 1'b1; core_o_addr = AW'(LEN - 1); core_data_out = DW'($urandom);
    for (int i = 0; i < hold; i++) begin
      step();
      total_cnt++;
      if (dst_we !== 1'b0) $display("FAIL extra_write got=%b exp=0", dst_we);
      else pass_cnt++;
    end
    core_done = 1'b1;
    if (finish_abort) begin cmd = CmdAbort; cmd_valid = 1'b1; end
    step();
    idle_inputs();
    total_cnt++;
    if (finish_abort) begin
      if ({frame_done, core_rst, busy} !== 3'b010)
        $display("FAIL abort_vs_done got=%b exp=010", {frame_done, core_rst, busy});
      else pass_cnt++;
    end else begin
      if ({frame_done, core_rst, busy} !== 3'b100)
        $display("FAIL done_pulse got=%b exp=100", {frame_done, core_rst, busy});
      else pass_cnt++;
      exp_bank = ~exp_bank;
      exp_fcount = (exp_fcount + 1) % 256;
    end
    step();
    total_cnt++;
    if ({frame_done, core_rst, busy} !== 3'b010)
      $display("FAIL post_frame got=%b exp=010", {frame_done, core_rst, busy});
    else pass_cnt++;
    total_cnt++;
    if (frame_count !== FW'(exp_fcount) || src_bank !== exp_bank || dst_bank !== exp_bank)
      $display("FAIL frame_status got=%0d/%b/%b exp=%0d/%b/%b", frame_count, src_bank,
               dst_bank, exp_fcount, exp_bank, exp_bank);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt - w0 !== LEN || fd_cnt - f0 !== (finish_abort ? 0 : 1))
      $display("FAIL frame_counts writes=%0d pulses=%0d exp=%0d/%0d", wr_cnt - w0,
               fd_cnt - f0, LEN, finish_abort ? 0 : 1);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [AW-1:0] wa;
    rst_n = 1'b0; idle_inputs(); core_w_addr = '0; core_o_addr = '0; core_data_out = '0;
    #3;
    total_cnt++;
    if (out_vec !== ResetVec) $display("FAIL reset_vals got=%h exp=%h", out_vec, ResetVec);
    else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (out_vec !== ResetVec) $display("FAIL idle_vals got=%h exp=%h", out_vec, ResetVec);
    else pass_cnt++;
    // Start without cmd_valid must be ignored.
    cmd = CmdStart;
    step(); step();
    total_cnt++;
    if ({core_rst, busy} !== 2'b10) $display("FAIL start_novalid got=%b exp=10",
                                             {core_rst, busy});
    else pass_cnt++;
    cmd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      wa = AW'($urandom);
      core_w_addr = wa;
      #1;
      total_cnt++;
      if (src_addr !== {1'b0, wa} || core_data_in !== src_mem[{1'b0, wa}])
        $display("FAIL idle_src_path got=%h/%h exp=%h/%h", src_addr, core_data_in,
                 {1'b0, wa}, src_mem[{1'b0, wa}]);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    int w0, f0;
    f0 = fd_cnt;
    cmd = CmdStart; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    w0 = wr_cnt;
    for (int i = 0; i < 149; i++) begin
      core_output_valid = (i < 60); core_o_addr = AW'(i); core_data_out = DW'($urandom);
      step();
    end
    // Abort in the same cycle as a valid beat: no write may follow.
    core_output_valid = 1'b1; core_o_addr = AW'(60); cmd = CmdAbort; cmd_valid = 1'b1;
    step();
    idle_inputs();
    total_cnt++;
    if ({core_rst, busy, dst_we} !== 3'b100)
      $display("FAIL abort_next got=%b exp=100", {core_rst, busy, dst_we});
    else pass_cnt++;
    repeat (5) step();
    total_cnt++;
    if (wr_cnt - w0 !== 60) $display("FAIL abort_writes got=%0d exp=60", wr_cnt - w0);
    else pass_cnt++;
    total_cnt++;
    if (fd_cnt !== f0 || frame_count !== FW'(exp_fcount) || src_bank !== exp_bank ||
        dst_bank !== exp_bank)
      $display("FAIL abort_status got=%0d/%0d/%b/%b exp=%0d/%0d/%b/%b", fd_cnt, frame_count,
               src_bank, dst_bank, f0, exp_fcount, exp_bank, exp_bank);
    else pass_cnt++;
  endtask

  task automatic test_nominal();
    run_frame(20, 20, 1'b0);
  endtask

  task automatic test_abort_vs_done();
    run_frame(3, 10, 1'b1);
  endtask

  task automatic test_hang();
    int n, f0;
    f0 = fd_cnt;
    cmd = CmdStart; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    n = 0;
    while (core_rst === 1'b0 && n < 1000) begin
      n++;
      step();
    end
    total_cnt++;
    if (n !== TO + 1) $display("FAIL hang_cycles got=%0d exp=%0d", n, TO + 1);
    else pass_cnt++;
    total_cnt++;
    if ({timeout_err, core_rst, busy} !== 3'b110)
      $display("FAIL err_state got=%b exp=110", {timeout_err, core_rst, busy});
    else pass_cnt++;
    cmd = CmdStart; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    total_cnt++;
    if ({timeout_err, core_rst, busy} !== 3'b110)
      $display("FAIL err_start_ignored got=%b exp=110", {timeout_err, core_rst, busy});
    else pass_cnt++;
    total_cnt++;
    if (fd_cnt !== f0 || frame_count !== FW'(exp_fcount) || src_bank !== exp_bank)
      $display("FAIL err_status got=%0d/%0d/%b exp=%0d/%0d/%b", fd_cnt, frame_count,
               src_bank, f0, exp_fcount, exp_bank);
    else pass_cnt++;
    cmd = CmdClear; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    total_cnt++;
    if ({timeout_err, core_rst, busy} !== 3'b010)
      $display("FAIL err_clear got=%b exp=010", {timeout_err, core_rst, busy});
    else pass_cnt++;
    run_frame(0, 30, 1'b0);
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_bank = 1'b0; exp_fcount = 0;
    step();
    for (int f = 0; f < 257; f++) run_frame(0, 0, 1'b0);
    total_cnt++;
    if (frame_count !== 8'd1 || src_bank !== 1'b1)
      $display("FAIL wrap got=%0d/%b exp=1/1", frame_count, src_bank);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int w0;
    cmd = CmdStart; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 50; i++) begin
      core_output_valid = 1'b1; core_o_addr = AW'(i); core_data_out = DW'($urandom);
      step();
    end
    core_o_addr = AW'(50);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_vec !== ResetVec) $display("FAIL async_reset got=%h exp=%h", out_vec, ResetVec);
    else pass_cnt++;
    step();
    idle_inputs();
    rst_n = 1'b1;
    exp_bank = 1'b0; exp_fcount = 0;
    step();
    w0 = wr_cnt;
    run_frame(5, 10, 1'b0);
    total_cnt++;
    if (wr_cnt - w0 !== LEN) $display("FAIL fresh_frame got=%0d exp=%0d", wr_cnt - w0, LEN);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) src_mem[i] = DW'($urandom);
    test_reset();
    test_abort();
    test_nominal();
    test_abort_vs_done();
    test_hang();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demosaic_frame_ctrl.md
# demosaic_frame_ctrl

Frame-level sequencer for the 10x10 Bayer demosaic core. It holds the core in reset until a start command arrives, then releases it for exactly one frame. It routes the core's pixel-read address to a ping-pong source frame store and captures the core's output stream into a ping-pong destination store. It also detects completion or hang, raises status, and flips banks so software can fill and drain alternate frames.

## Interface
Parameters:
- DATA_WIDTH, 12, pixel word width ({R,G,B} 4b each on output; raw Bayer sample on input)
- ADDR_WIDTH, 7, core pixel address width
- DATA_LENGTH, 100, pixels per frame
- TIMEOUT_CYCLES, 4095, max cycles from core release to last captured pixel
- FCNT_W, 8, frame counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd  in  2  command: 00 nop, 01 start, 10 abort, 11 clear status
- cmd_valid  in  1  cmd sampled only when high
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on successful frame
- timeout_err  out  1  sticky hang flag
- frame_count  out  FCNT_W  completed frames, wraps
- src_bank  out  1  source bank the core reads
- dst_bank  out  1  destination bank being written
- core_rst  out  1  active-high reset to core
- core_w_addr  in  ADDR_WIDTH  core read address
- core_data_in  out  DATA_WIDTH  sample to core
- src_addr  out  ADDR_WIDTH+1  {src_bank, core_w_addr}
- src_data  in  DATA_WIDTH  source store read data (combinational read)
- core_o_addr  in  ADDR_WIDTH  core output address
- core_data_out  in  DATA_WIDTH  core output pixel
- core_output_valid  in  1  core output strobe
- core_done  in  1  core finished flag
- dst_we  out  1  destination write enable
- dst_addr  out  ADDR_WIDTH+1  {dst_bank, captured o_addr}
- dst_data  out  DATA_WIDTH  captured pixel

## Operation
- Reset values: busy 0, frame_done 0, timeout_err 0, frame_count 0, src_bank 0, dst_bank 0, core_rst 1, dst_we 0, dst_addr 0, dst_data 0; state IDLE.
- core_data_in = src_data, and src_addr = {src_bank, core_w_addr}. Both are combinational.
- States:
  - IDLE: core_rst=1, busy=0.
    - cmd 01 -> REL.
    - cmd 11 clears timeout_err.
    - cmd 10 is a no-op.
  - REL: one cycle. core_rst still 1; clear the capture count and the cycle counter. Go to RUN.
  - RUN: core_rst=0, busy=1, cycle counter increments every cycle.
    - Capture: when core_output_valid=1 and capture count < DATA_LENGTH, register dst_we=1, dst_addr={dst_bank, core_o_addr}, dst_data=core_data_out, and increment the count.
    - Ignore valid beats after DATA_LENGTH captures, because the core holds valid in its finish state.
    - When count reaches DATA_LENGTH and core_done=1 -> DONE.
  - DONE: one cycle.
    - frame_done=1, frame_count+1 (wraps).
    - Toggle src_bank and dst_bank.
    - core_rst=1 -> IDLE.
  - ERR: entered from RUN when the cycle counter reaches TIMEOUT_CYCLES.
    - timeout_err=1, core_rst=1, busy=0.
    - No bank flip, no count.
    - cmd 11 -> IDLE with timeout_err cleared. Start is ignored in ERR.
- Abort (cmd 10) in REL or RUN:
  - Next cycle: core_rst=1, state IDLE, dst_we=0.
  - No frame_done, no bank flip, frame_count unchanged.
  - Already-written destination words are left as-is.
- Start while busy or in ERR: ignored.
- Abort and core completion in the same cycle: abort wins.

## Timing
- Start accepted at edge N: REL is active in cycle N+1, and core_rst deasserts at edge N+2.
- Capture latency: a valid beat at edge k produces dst_we/dst_addr/dst_data registered at edge k+1, so dst_we is high during cycle k+1. Back-to-back beats produce back-to-back writes.
- frame_done is high exactly one cycle, in the cycle after the completion condition is met. busy falls in the same cycle frame_done rises; core_rst rises the cycle after.
- Timeout: when the cycle counter equals TIMEOUT_CYCLES, ERR is entered at the next edge. A completion in that same cycle takes priority over the timeout.
- rst_n asserted mid-frame: all outputs return to their reset values immediately (asynchronous); banks return to 0.
- Counter widths:
  - Capture count: ADDR_WIDTH+1 bits.
  - Cycle counter: clog2(TIMEOUT_CYCLES+1) bits, saturating.

## Test plan
- Nominal frame: source bank 0 holds a known Bayer pattern; issue cmd 01, then run the core model.
  - Exactly 100 dst_we pulses at addresses 0..99 in bank 0.
  - One frame_done pulse; frame_count 1; src_bank and dst_bank both 1.
- Valid held after the last beat: core keeps output_valid=1 with o_addr=99 for 20 cycles. Required: no 101st write.
- Abort at RUN cycle 150, then issue a new start.
  - Abort: core_rst=1 next cycle; no frame_done; banks stay 0; frame_count stays 0.
  - New start: runs a full frame into bank 0.
- Hang with TIMEOUT_CYCLES=300: core never asserts done.
  - timeout_err rises at RUN cycle 301; start is ignored.
  - cmd 11 clears the flag; a subsequent start works.
- Back-to-back frames: 257 frames. frame_count wraps to 1, and the banks alternate every frame.
- rst_n pulled low during capture of pixel 50: all outputs return to reset values immediately, and the next start begins a fresh frame.
